// File: rtl/common.sv
// Shared CPU data-bus types.
//   msize_t          - access size encoding (1/2/4/8 bytes)
//   dbus_req_t       - request: valid, addr, size, strobe, data
//   dbus_resp_t      - response: addr_ok, data_ok, data
//   dbus_rsp_state_t - responder FSM states
//   msize_mask()     - legal byte-strobe lane for a size at a byte offset
package common;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dbus_rsp_state_t;

    // Bytes covered by an access of 'size' starting at byte offset 'off'.
    function automatic logic [7:0] msize_mask(msize_t size, logic [2:0] off);
        logic [7:0] lane;
        case (size)
            MSIZE1:  lane = 8'h01;
            MSIZE2:  lane = 8'h03;
            MSIZE4:  lane = 8'h0F;
            default: lane = 8'hFF;
        endcase
        return lane << off;
    endfunction

endpackage

// File: rtl/dbus_sram_bank.sv
// DEPTH x 64-bit storage with per-byte write enables and a registered read port.
//   clk    - clock
//   reset  - asynchronous active-high reset (read register only; array is not reset)
//   en     - access enable for this cycle
//   wstrb  - byte write enables; zero means the access is a read
//   idx    - word index
//   wdata  - write data
//   rdata  - registered read data; zero after any cycle that was not a read
module dbus_sram_bank #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [7:0]               wstrb,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [63:0]              wdata,
    output logic [63:0]              rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Cleared on non-read cycles so write responses carry zero data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && (wstrb == 8'h00)) begin
            rdata <= mem[idx];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by a byte-strobed 64-bit SRAM with fixed latency.
// One outstanding request; addr_ok in the acceptance cycle t, data_ok in t+LATENCY.
//   clk    - clock
//   reset  - asynchronous active-high reset
//   dreq   - request from the CPU memory stage
//   dresp  - response to the CPU (data is zero whenever data_ok is low)
//   err    - protocol-violation pulse with data_ok (only when DBUS_CHECK_EN is defined)
// Optional feature: define DBUS_CHECK_EN to enable alignment/strobe checking.
module dbus_sram_responder
    import common::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
`ifdef DBUS_CHECK_EN
    ,
    output logic       err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

    dbus_rsp_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [AW-1:0] idx_q;
    logic [7:0]    strobe_q;
    logic [63:0]   data_q;
    logic          viol_q;

    logic          accept;
    logic [63:0]   offset;
    logic [AW-1:0] req_idx;
    logic          viol;

    logic          commit;
    logic          mem_en;
    logic [AW-1:0] mem_idx;
    logic [7:0]    mem_strb;
    logic [63:0]   mem_wdata;
    logic          mem_viol;
    logic [63:0]   rdata;

    assign accept  = (state_q == IDLE) && dreq.valid;
    // Out-of-window addresses wrap: only the index bits of the offset matter.
    assign offset  = dreq.addr - BASE;
    assign req_idx = offset[AW+2:3];

`ifdef DBUS_CHECK_EN
    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (dreq.size)
            MSIZE1:  misaligned = 1'b0;
            MSIZE2:  misaligned = dreq.addr[0];
            MSIZE4:  misaligned = |dreq.addr[1:0];
            default: misaligned = |dreq.addr[2:0];
        endcase
    end

    assign viol = misaligned || |(dreq.strobe & ~msize_mask(dreq.size, dreq.addr[2:0]));
`else
    assign viol = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{offset[63:AW+3], offset[2:0], dreq.size};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = CW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            strobe_q <= '0;
            data_q   <= '0;
            viol_q   <= 1'b0;
        end else if (accept) begin
            idx_q    <= req_idx;
            strobe_q <= dreq.strobe;
            data_q   <= dreq.data;
            viol_q   <= viol;
        end
    end

    // With LATENCY == 1 the access edge is the acceptance edge, so the live
    // request feeds the bank; otherwise the latched copy does.
    always_comb begin
        if (state_q == IDLE) begin
            mem_idx   = req_idx;
            mem_strb  = dreq.strobe;
            mem_wdata = dreq.data;
            mem_viol  = viol;
        end else begin
            mem_idx   = idx_q;
            mem_strb  = strobe_q;
            mem_wdata = data_q;
            mem_viol  = viol_q;
        end
    end

    // A violating access touches nothing, so its response data is zero too.
    assign mem_en = commit && !mem_viol;

    dbus_sram_bank #(
        .DEPTH(DEPTH)
    ) u_bank (
        .clk  (clk),
        .reset(reset),
        .en   (mem_en),
        .wstrb(mem_strb),
        .idx  (mem_idx),
        .wdata(mem_wdata),
        .rdata(rdata)
    );

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = accept && !reset;
        dresp.data_ok = (state_q == RESP);
        dresp.data    = (state_q == RESP) ? rdata : 64'h0;
    end

`ifdef DBUS_CHECK_EN
    assign err = (state_q == RESP) && viol_q;
`endif

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: three instances with LATENCY 1, 2 and 3 share
// clock and reset. A timeline model predicts every output each cycle.
module tb_dbus_sram_responder;
    import common::*;

    localparam int          NI    = 3;
    localparam int unsigned DEPTH = 16;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    dbus_req_t  dreq  [NI];
    dbus_resp_t dresp [NI];
`ifdef DBUS_CHECK_EN
    logic       err   [NI];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dbus_sram_responder #(
            .DEPTH  (DEPTH),
            .LATENCY(g + 1),
            .BASE   (BASE)
        ) u_dut (
            .clk  (clk),
            .reset(reset),
            .dreq (dreq[g]),
            .dresp(dresp[g])
`ifdef DBUS_CHECK_EN
            ,
            .err  (err[g])
`endif
        );
    end

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    bit started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    // ---------------- behavioural model ----------------
    logic [63:0] mmem [NI][DEPTH];
    bit          pend      [NI];
    int          p_acc     [NI];
    int          p_idx     [NI];
    logic [7:0]  p_strb    [NI];
    logic [63:0] p_wdata   [NI];
    bit          p_viol    [NI];
    logic [63:0] p_rdata   [NI];
    int          next_free [NI];

    // DUT observations for literal checks
    int          last_acc  [NI];
    int          last_ok   [NI];
    logic [63:0] last_data [NI];
    bit          last_err  [NI];
    int          ok_cnt    [NI];
    int          acc_q0 [$];
    int          ok_q0  [$];

    function automatic int midx(input logic [63:0] a);
        logic [63:0] o;
        o = a - BASE;
        return int'((o >> 3) % 64'(DEPTH));
    endfunction

    function automatic bit model_viol(input msize_t s, input logic [63:0] a,
                                      input logic [7:0] strb);
`ifdef DBUS_CHECK_EN
        int n;
        int off;
        n   = 1 << int'(s);
        off = int'(a[2:0]);
        if (off % n != 0) return 1'b1;
        for (int i = 0; i < 8; i++)
            if (strb[i] && (i < off || i >= off + n)) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            int          lat;
            bit          e_aok;
            bit          e_dok;
            bit          e_err;
            logic [63:0] e_data;
            lat    = k + 1;
            e_aok  = 1'b0;
            e_dok  = 1'b0;
            e_err  = 1'b0;
            e_data = 64'h0;
            if (reset) begin
                pend[k]      = 1'b0;
                next_free[k] = 0;
            end else begin
                if (dreq[k].valid && cyc >= next_free[k]) begin
                    e_aok        = 1'b1;
                    pend[k]      = 1'b1;
                    p_acc[k]     = cyc;
                    p_idx[k]     = midx(dreq[k].addr);
                    p_strb[k]    = dreq[k].strobe;
                    p_wdata[k]   = dreq[k].data;
                    p_viol[k]    = model_viol(dreq[k].size, dreq[k].addr, dreq[k].strobe);
                    next_free[k] = cyc + lat + 1;
                end
                if (pend[k] && cyc == p_acc[k] + lat - 1) begin
                    p_rdata[k] = 64'h0;
                    if (!p_viol[k]) begin
                        if (p_strb[k] != 8'h00) begin
                            for (int i = 0; i < 8; i++)
                                if (p_strb[k][i])
                                    mmem[k][p_idx[k]][8*i +: 8] = p_wdata[k][8*i +: 8];
                        end else begin
                            p_rdata[k] = mmem[k][p_idx[k]];
                        end
                    end
                end
                if (pend[k] && cyc == p_acc[k] + lat) begin
                    e_dok   = 1'b1;
                    e_data  = p_rdata[k];
                    e_err   = p_viol[k];
                    pend[k] = 1'b0;
                end
            end
            if (started) begin
                chk($sformatf("addr_ok[%0d]@%0d", k, cyc), 64'(dresp[k].addr_ok), 64'(e_aok));
                chk($sformatf("data_ok[%0d]@%0d", k, cyc), 64'(dresp[k].data_ok), 64'(e_dok));
                chk($sformatf("data[%0d]@%0d", k, cyc), dresp[k].data, e_data);
`ifdef DBUS_CHECK_EN
                chk($sformatf("err[%0d]@%0d", k, cyc), 64'(err[k]), 64'(e_err));
`endif
            end
            if (dresp[k].addr_ok === 1'b1) begin
                last_acc[k] = cyc;
                if (k == 0) acc_q0.push_back(cyc);
            end
            if (dresp[k].data_ok === 1'b1) begin
                last_ok[k]   = cyc;
                last_data[k] = dresp[k].data;
                ok_cnt[k]++;
`ifdef DBUS_CHECK_EN
                last_err[k]  = err[k];
`else
                last_err[k]  = 1'b0;
`endif
                if (k == 0) ok_q0.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    int last_drive [NI];

    // Starts and ends 1 time unit after a rising edge.
    task automatic txn(input int k, input logic [63:0] a, input logic [7:0] s,
                       input logic [63:0] d, input msize_t sz);
        last_drive[k]   = cyc;
        dreq[k].valid  = 1'b1;
        dreq[k].addr   = a;
        dreq[k].size   = sz;
        dreq[k].strobe = s;
        dreq[k].data   = d;
        repeat (k + 2) @(posedge clk);
        #1;
        dreq[k].valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input int k, input logic [63:0] a, input logic [63:0] lit,
                            input string name);
        txn(k, a, 8'h00, 64'h0, MSIZE8);
        chk({name, "_data"}, last_data[k], lit);
        chk({name, "_acc"}, 64'(last_acc[k]), 64'(last_drive[k]));
        chk({name, "_lat"}, 64'(last_ok[k] - last_drive[k]), 64'(k + 1));
    endtask

    initial begin
        int n0;
        int c0;
        for (int k = 0; k < NI; k++) begin
            dreq[k]   = '0;
            ok_cnt[k] = 0;
        end
        #1 reset = 1'b1;
        started = 1'b1;
        idle(3);
        chk("reset_data_ok", 64'(dresp[1].data_ok), 64'h0);
        chk("reset_data", dresp[1].data, 64'h0);
        reset = 1'b0;

        // Fill every word so later reads are fully predictable.
        for (int k = 0; k < NI; k++)
            for (int w = 0; w < int'(DEPTH); w++)
                txn(k, BASE + 64'(w) * 64'd8, 8'hFF, {$urandom, $urandom}, MSIZE8);

        // Full write then read-back, LATENCY 2.
        txn(1, BASE + 64'd8, 8'hFF, 64'h1122_3344_5566_7788, MSIZE8);
        chk("wr_acc", 64'(last_acc[1]), 64'(last_drive[1]));
        chk("wr_lat", 64'(last_ok[1] - last_drive[1]), 64'd2);
        rd_check(1, BASE + 64'd8, 64'h1122_3344_5566_7788, "rd_full");

        // Partial strobe.
        txn(1, BASE + 64'd8, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, MSIZE8);
        rd_check(1, BASE + 64'd8, 64'h1122_3344_BBBB_BBBB, "rd_partial");

        // Aliasing above and below the window.
        txn(1, BASE, 8'hFF, 64'h5, MSIZE8);
        rd_check(1, BASE + 64'(DEPTH) * 64'd8, 64'h5, "alias_hi");
        txn(1, BASE + 64'(DEPTH - 1) * 64'd8, 8'hFF, 64'hDEAD_BEEF_0000_0F0F, MSIZE8);
        rd_check(1, BASE - 64'd8, 64'hDEAD_BEEF_0000_0F0F, "alias_lo");

        // Reset during WAIT of a LATENCY 3 write drops it.
        txn(2, BASE + 64'd16, 8'hFF, 64'h0123_4567_0000_1616, MSIZE8);
        n0 = ok_cnt[2];
        dreq[2].valid  = 1'b1;
        dreq[2].addr   = BASE + 64'd16;
        dreq[2].strobe = 8'hFF;
        dreq[2].data   = 64'hFFFF_FFFF_FFFF_FFFF;
        idle(1);
        reset = 1'b1;
        #1;
        chk("rst_mid_data_ok", 64'(dresp[2].data_ok), 64'h0);
        chk("rst_mid_addr_ok", 64'(dresp[2].addr_ok), 64'h0);
        chk("rst_mid_data", dresp[2].data, 64'h0);
        idle(1);
        dreq[2].valid = 1'b0;
        idle(1);
        reset = 1'b0;
        idle(4);
        chk("rst_mid_no_ok", 64'(ok_cnt[2]), 64'(n0));
        rd_check(2, BASE + 64'd16, 64'h0123_4567_0000_1616, "rst_mid_rd");

        // LATENCY 1 with valid held high across two requests.
        acc_q0.delete();
        ok_q0.delete();
        c0 = cyc;
        txn(0, BASE + 64'd24, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, MSIZE8);
        txn(0, BASE + 64'd24, 8'h00, 64'h0, MSIZE8);
        idle(2);
        chk("b2b_acc_n", 64'(acc_q0.size()), 64'd2);
        chk("b2b_ok_n", 64'(ok_q0.size()), 64'd2);
        if (acc_q0.size() == 2 && ok_q0.size() == 2) begin
            chk("b2b_acc0", 64'(acc_q0[0]), 64'(c0));
            chk("b2b_ok0", 64'(ok_q0[0]), 64'(c0 + 1));
            chk("b2b_acc1", 64'(acc_q0[1]), 64'(c0 + 2));
            chk("b2b_ok1", 64'(ok_q0[1]), 64'(c0 + 3));
        end
        chk("b2b_data", last_data[0], 64'h0F0E_0D0C_0B0A_0908);

`ifdef DBUS_CHECK_EN
        txn(1, BASE, 8'hFF, 64'h0123_4567_89AB_CDEF, MSIZE8);
        txn(1, BASE + 64'd2, 8'h3C, 64'hFFFF_FFFF_FFFF_FFFF, MSIZE4);
        chk("viol_err", 64'(last_err[1]), 64'h1);
        chk("viol_lat", 64'(last_ok[1] - last_drive[1]), 64'd2);
        chk("viol_data", last_data[1], 64'h0);
        rd_check(1, BASE, 64'h0123_4567_89AB_CDEF, "viol_unchanged");
        txn(1, BASE + 64'd4, 8'hF0, 64'h5555_5555_6666_6666, MSIZE4);
        chk("aligned_err", 64'(last_err[1]), 64'h0);
        rd_check(1, BASE, 64'h5555_5555_89AB_CDEF, "aligned_rd");
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 300; n++) begin
            int          k;
            int          w;
            logic [63:0] a;
            logic [7:0]  s;
            k = $urandom_range(0, NI - 1);
            w = $urandom_range(0, 60) - 20;
            a = BASE + 64'(w) * 64'd8 + 64'($urandom_range(0, 7));
            s = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            txn(k, a, s, {$urandom, $urandom}, msize_t'($urandom_range(0, 3)));
            idle($urandom_range(0, 2));
        end
        idle(4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
- Responder end of the CPU data bus: accepts `dbus_req_t` from the memory stage and returns `dbus_resp_t`.
- Backed by a byte-strobed, 64-bit-wide SRAM with a programmable fixed latency.
- Serves as the simulation/FPGA data memory in place of a cache, and as the reference responder when verifying the memory stage.
- Supports one outstanding request at a time.

Parameters:
- DEPTH, 1024, number of 64-bit words in the backing store; must be a power of two.
- LATENCY, 2, cycles from request acceptance to `data_ok`; minimum 1.
- BASE, 64'h8000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- dreq  input  dbus_req_t  request from the CPU: valid, addr, size, strobe, data.
- dresp  output  dbus_resp_t  response to the CPU: addr_ok, data_ok, data.
- err  output  1  protocol-violation pulse; this port exists only when DBUS_CHECK_EN is defined.

Behaviour:
- Interface decision: one clock (`clk`); `reset` is asynchronous and active-high.
- Reset values: FSM state = IDLE, counter = 0, `dresp.addr_ok` = 0, `dresp.data_ok` = 0, `dresp.data` = 0, `err` = 0. SRAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `addr_ok = dreq.valid`, driven combinationally.
  - On a cycle where valid is high (cycle t), latch addr, strobe, data and size.
  - Load the counter with LATENCY-1.
  - Next state: RESP if LATENCY == 1, else WAIT.
- WAIT:
  - `addr_ok` = 0.
  - Counter decrements each cycle; go to RESP when it reaches 1 → 0.
- RESP:
  - `data_ok` = 1 for exactly one cycle (cycle t+LATENCY), then return to IDLE.
  - `dreq` is ignored during RESP.
- Latency: `data_ok` is asserted in cycle t+LATENCY exactly.
  - Back-to-back throughput: one request per LATENCY+1 cycles.
  - A next request may be accepted in the cycle after `data_ok`.
- Requester obligation: hold valid and request fields stable from acceptance until `data_ok`. The responder uses only the latched copy.
- Address mapping: `index = ((addr - BASE) >> 3) mod DEPTH`. Addresses outside the window alias (wrap); no fault is raised.
- Write vs. read: a request with `strobe != 0` is a write, otherwise a read.
- Memory access timing: the SRAM access happens at the edge that ends cycle t+LATENCY-1.
  - Write: byte i of the word is updated iff `strobe[i]`.
  - Read: the full aligned 64-bit word is registered into `dresp.data`.
- Response data:
  - Reads return the whole word; byte/half/word extraction and sign-extension belong to the memory stage.
  - Writes return `dresp.data` = 0.
- `dresp.data` is zero in all cycles where `data_ok` = 0.
- Reset mid-operation (in WAIT or RESP): the pending request is dropped, no `data_ok` is issued, and the FSM returns to IDLE.
  - A write is committed only if its commit edge occurred before reset assertion.
- `size` is ignored unless DBUS_CHECK_EN is defined.

Optional Feature:
- Macro: DBUS_CHECK_EN.
- When defined:
  - At acceptance, check that addr is aligned to size: MSIZE1 any; MSIZE2 addr[0]=0; MSIZE4 addr[1:0]=0; MSIZE8 addr[2:0]=0.
  - Check that strobe has no bits set outside the sized lane.
  - On violation, the write is suppressed (memory unchanged), `data_ok` is still issued at the normal latency with data 0, and `err` pulses high in the same cycle as `data_ok`.
- When undefined: the `err` port and all checking logic are absent; behaviour is otherwise identical.

Decomposition:
- `dbus_req_t`, `dbus_resp_t` and the msize enum stay in package `common`.
- Add to `common`: a state enum `dbus_rsp_state_t` {IDLE, WAIT, RESP} and the function `msize_mask(size, addr[2:0])` returning the legal strobe mask.
- One sub-module: `dbus_sram_bank`, a DEPTH×64 array with byte write-enable and registered synchronous read.

Test Plan:
- Reset, then write 64'h1122_3344_5566_7788 to BASE+8 with strobe 8'hFF (LATENCY=2) → addr_ok in cycle 0, data_ok only in cycle 2. Subsequent read of BASE+8 returns 64'h1122_3344_5566_7788 with data_ok 2 cycles after acceptance.
- Write 64'hAAAA_AAAA_BBBB_BBBB with strobe 8'h0F to the same address, then read → 64'h1122_3344_BBBB_BBBB.
- Write 64'h5 to BASE, then read BASE + DEPTH*8 (alias) → 64'h5. Read BASE-8 → same value as word DEPTH-1.
- Assert reset during WAIT of a write to BASE+16 (LATENCY=3, reset at cycle 1) → no data_ok, dresp all zero, next read of BASE+16 returns the pre-write value.
- Valid held high across two requests (LATENCY=1) → addr_ok in cycles 0 and 2, data_ok in cycles 1 and 3, no duplicate acceptance during RESP.
- With DBUS_CHECK_EN: MSIZE4 write at BASE+2 with strobe 8'h3C → err=1 with data_ok at cycle LATENCY, memory word unchanged. Aligned MSIZE4 at BASE+4 with strobe 8'hF0 → err=0.
